// File: rtl/sc_count_expander.sv
// Count-to-thermometer expander: a loaded count becomes a ROW_WIDTH pattern
// with min(count, ROW_WIDTH) ones, LSB first. The pattern is held in parallel
// on row_Out and streamed one bit per beat over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a load; serial stream quiet
// SHIFT | streaming the pattern, one beat per accepted handshake
module sc_count_expander #(
   parameter int COUNT_WIDTH = 3,
   parameter int ROW_WIDTH   = 4
) (
   input  logic                   SC_CountEXPANDER_CLOCK_50,
   input  logic                   SC_CountEXPANDER_RESET_InLow,
   input  logic [COUNT_WIDTH-1:0] SC_CountEXPANDER_count_In,
   input  logic                   SC_CountEXPANDER_load_In,
   output logic                   SC_CountEXPANDER_ready_Out,
   output logic [ROW_WIDTH-1:0]   SC_CountEXPANDER_row_Out,
   output logic                   SC_CountEXPANDER_overflow_Out,
   output logic                   SC_CountEXPANDER_serial_Out,
   output logic                   SC_CountEXPANDER_serialValid_Out,
   output logic                   SC_CountEXPANDER_serialLast_Out,
   input  logic                   SC_CountEXPANDER_serialReady_In
);

   localparam int IDX_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                 state_q;
   logic [ROW_WIDTH-1:0]   row_q;
   logic                   ovf_q;
   logic [ROW_WIDTH-1:0]   shreg_q;
   logic [IDX_W-1:0]       idx_q;

   logic [ROW_WIDTH-1:0]   pattern_d;
   logic                   ovf_d;
   logic [31:0]            count_ext;

   // Thermometer decode of the incoming count; counts above ROW_WIDTH saturate.
   always_comb begin
      pattern_d = '0;
      count_ext = {{(32-COUNT_WIDTH){1'b0}}, SC_CountEXPANDER_count_In};
      for (int i = 0; i < ROW_WIDTH; i++) begin
         pattern_d[i] = (count_ext > 32'(i));
      end
      ovf_d = (count_ext > 32'(ROW_WIDTH));
   end

   // Load/shift FSM; a beat only advances when downstream takes it, so a stall
   // leaves the shift register and index untouched.
   always_ff @(posedge SC_CountEXPANDER_CLOCK_50) begin
      if (!SC_CountEXPANDER_RESET_InLow) begin
         state_q <= IDLE;
         row_q   <= '0;
         ovf_q   <= 1'b0;
         shreg_q <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (SC_CountEXPANDER_load_In) begin
                  row_q   <= pattern_d;
                  ovf_q   <= ovf_d;
                  shreg_q <= pattern_d;
                  idx_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (SC_CountEXPANDER_serialReady_In) begin
                  shreg_q <= shreg_q >> 1;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs decode only registered state, so no input reaches them combinationally.
   // shreg_q is fully shifted out by the end of a transfer, so serial_Out idles at 0.
   assign SC_CountEXPANDER_ready_Out       = (state_q == IDLE);
   assign SC_CountEXPANDER_row_Out         = row_q;
   assign SC_CountEXPANDER_overflow_Out    = ovf_q;
   assign SC_CountEXPANDER_serial_Out      = shreg_q[0];
   assign SC_CountEXPANDER_serialValid_Out = (state_q == SHIFT);
   assign SC_CountEXPANDER_serialLast_Out  = (state_q == SHIFT) && (idx_q == LAST_IDX);

endmodule
